butterfly_lsu: RTL
==================

Name: butterfly_lsu

Overview:
- Parametrised load/store unit replacing the direct store-only MEM stage of the ButterFly RV32IM core.
- Accepts one memory request from EX/MEM and supports byte, half and word sizes, plus sign or zero extension on loads.
- Holds the data-memory request stable until the memory handshakes, and raises a pipeline stall meanwhile.
- Returns load data for writeback and traps misaligned or timed-out accesses.

Parameters:
- ADDR_W, 32, byte-address width of request and data-memory bus.
- TIMEOUT_CYCLES, 0, maximum BUS-state cycles without dmem_ready_i before a bus error; 0 disables the timeout.
- TIMEOUT_W, 8, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_W.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  EX/MEM holds a load or store.
- req_ready_o  out  1  LSU can accept a request; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  in  1  zero-extend load (LBU/LHU).
- req_rd_i  in  5  load destination register.
- stall_o  out  1  equals (state == BUS); freezes upstream stages.
- dmem_valid_o  out  1  bus request.
- dmem_we_o  out  1  bus write.
- dmem_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_wstrb_o  out  4  byte strobes; 0000 on loads.
- dmem_rdata_i  in  32  read data, valid with dmem_ready_i.
- dmem_ready_i  in  1  transfer completes at this edge.
- wb_valid_o  out  1  one-cycle load-result pulse.
- wb_rd_o  out  5  load destination register.
- wb_data_o  out  32  extended load data.
- exc_misaligned_o  out  1  one-cycle misaligned or illegal-size pulse.
- exc_buserr_o  out  1  one-cycle timeout pulse.
- exc_addr_o  out  ADDR_W  faulting byte address.

Behaviour:
- Reset (synchronous, rst_n_i low at an edge):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready_o = 1.
  - Any in-flight transaction is abandoned; dmem_valid_o is low the cycle after the reset edge.
- States: IDLE and BUS. No other states.
- IDLE, req_valid_i high, alignment check:
  - Misaligned means half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
  - Misaligned: no bus access; exc_misaligned_o and exc_addr_o are registered (pulse next cycle); state stays IDLE.
- IDLE, aligned request:
  - Register we, address, size, unsigned, rd, strobes and lane data; go to BUS.
  - dmem_valid_o rises the next cycle.
- Store strobes and data:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 << (2*addr[1]); wdata = half replicated x2.
  - SW: wstrb = 1111; wdata unchanged.
- BUS state:
  - dmem_valid_o = 1, and all dmem_* outputs are held constant until an edge where dmem_ready_i = 1.
  - On that edge, return to IDLE; dmem_valid_o is low the next cycle.
  - dmem_ready_i is ignored outside BUS.
- Load completion (ready edge):
  - Select lane by the registered addr[1:0].
  - Extend: sign-extend from bit 7 or 15 unless unsigned; word loads pass through.
  - wb_valid_o, wb_rd_o and wb_data_o are registered and valid for exactly the cycle after the ready edge.
  - Stores never assert wb_valid_o.
  - wb_rd_o = 0 still pulses wb_valid_o; the regfile ignores x0.
- Latency: request accepted at edge N, dmem_valid_o high in cycle N+1, zero-wait ready at edge N+1 gives wb_valid_o in cycle N+2. Throughput is one access per 2 cycles minimum.
- Timeout:
  - Applies only if TIMEOUT_CYCLES > 0.
  - The counter clears on BUS entry and increments each BUS cycle without ready.
  - When the count reaches TIMEOUT_CYCLES: pulse exc_buserr_o, set exc_addr_o, drop dmem_valid_o, go to IDLE, no writeback.
  - If ready and timeout fall on the same edge, ready wins and no error is raised.
- Only one outstanding access at a time. req_valid_i while in BUS is ignored (stall_o holds it upstream).
- Back-to-back: the first IDLE cycle after completion can accept the next request.

Test Plan:
- Reset, then SW addr 0x100, wdata 0xDEADBEEF, ready 0 wait -> dmem_valid_o=1, we=1, addr=0x100, wstrb=1111 in cycle N+1; req_ready_o=0 exactly 1 cycle.
- SB addr 0x103, wdata 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5. SH addr 0x102, wdata 0x1234 -> wstrb=1100, wdata=0x12341234.
- LB addr 0x201, rdata 0x0000_80_00, rd=5 -> wb_valid_o pulse, wb_rd_o=5, wb_data_o=0xFFFFFF80. Same access with LBU -> 0x00000080. LH addr 0x202, rdata 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x206 -> exc_misaligned_o one pulse, exc_addr_o=0x206, dmem_valid_o never asserts. Size 11 at 0x200 -> same behaviour.
- Hold ready low 3 cycles during an LW -> dmem_* outputs stable, stall_o=1 for 4 cycles, single wb pulse. With TIMEOUT_CYCLES=4 and ready never asserted -> exc_buserr_o pulse, return to IDLE, no wb_valid_o.
- Drop rst_n_i for one edge mid-BUS -> dmem_valid_o=0 next cycle, req_ready_o=1, no wb or exception pulse; a new LW then completes normally.

Source files
------------

// File: rtl/butterfly_lsu.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_lsu
// Purpose  : Load/store unit for the ButterFly RV32IM MEM stage. Accepts one
//            byte/half/word request, drives a stable data-memory request
//            until the memory handshakes, stalls the pipeline meanwhile,
//            returns extended load data and reports misaligned or timed-out
//            accesses.
// Ports    : clk_i, rst_n_i           - clock, synchronous active-low reset
//            req_*                    - request from EX/MEM (valid/ready)
//            stall_o                  - high while a bus access is in flight
//            dmem_*                   - data-memory bus (valid/ready)
//            wb_valid_o/rd_o/data_o   - one-cycle load writeback pulse
//            exc_misaligned_o,
//            exc_buserr_o, exc_addr_o - one-cycle exception pulses + address
// Revision : 1.0 - initial release
// ============================================================================
module butterfly_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [4:0]        req_rd_i,
    output logic              stall_o,
    output logic              dmem_valid_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_wstrb_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ready_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              exc_misaligned_o,
    output logic              exc_buserr_o,
    output logic [ADDR_W-1:0] exc_addr_o
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUS  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    // Captured request
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;

    // Registered result / exception pulses
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_exc_mis;
    logic              r_exc_bus;
    logic [ADDR_W-1:0] r_exc_addr;

    logic              w_misaligned;
    logic              w_accept;
    logic              w_timeout;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size_i)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr_i[0];
            2'b10:   w_misaligned = (req_addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_accept = (r_state == c_ST_IDLE) && req_valid_i && !w_misaligned;

    // Store lanes: data is replicated across the word so the strobes alone
    // select which bytes the memory actually writes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                w_wstrb = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {req_addr_i[1], 1'b0};
                w_wdata = {2{req_wdata_i[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata_i;
            end
        endcase
        if (!req_we_i) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load lane select and extension, using the captured byte offset
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = dmem_rdata_i;
        case (r_addr[1:0])
            2'b00:   w_byte = dmem_rdata_i[7:0];
            2'b01:   w_byte = dmem_rdata_i[15:8];
            2'b10:   w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h000000, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'h0000, w_half}
                                              : {{16{w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus wait timeout. Fires on the edge that would complete the
    // TIMEOUT_CYCLES-th BUS cycle without ready; a simultaneous ready wins.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [TIMEOUT_W-1:0] c_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
            logic [TIMEOUT_W-1:0] r_wait_cnt;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_wait_cnt <= '0;
                end else if (r_state == c_ST_IDLE) begin
                    r_wait_cnt <= '0;
                end else if (!dmem_ready_i) begin
                    r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
                end
            end

            assign w_timeout = (r_state == c_ST_BUS) && !dmem_ready_i
                               && (r_wait_cnt == c_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)                  w_state_nxt = c_ST_BUS;
            default:   if (dmem_ready_i || w_timeout) w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (r_state == c_ST_IDLE);
        stall_o      = (r_state == c_ST_BUS);
        dmem_valid_o = (r_state == c_ST_BUS);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_rd       <= 5'd0;
            r_wstrb    <= 4'b0000;
            r_wdata    <= 32'h0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'h0;
            r_exc_mis  <= 1'b0;
            r_exc_bus  <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_exc_mis  <= 1'b0;
            r_exc_bus  <= 1'b0;

            if (r_state == c_ST_IDLE && req_valid_i) begin
                if (w_misaligned) begin
                    r_exc_mis  <= 1'b1;
                    r_exc_addr <= req_addr_i;
                end else begin
                    r_we       <= req_we_i;
                    r_addr     <= req_addr_i;
                    r_size     <= req_size_i;
                    r_unsigned <= req_unsigned_i;
                    r_rd       <= req_rd_i;
                    r_wstrb    <= w_wstrb;
                    r_wdata    <= w_wdata;
                end
            end

            if (r_state == c_ST_BUS) begin
                if (dmem_ready_i) begin
                    if (!r_we) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                    end
                end else if (w_timeout) begin
                    r_exc_bus  <= 1'b1;
                    r_exc_addr <= r_addr;
                end
            end
        end
    end

    assign dmem_we_o        = r_we;
    assign dmem_addr_o      = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o     = r_wdata;
    assign dmem_wstrb_o     = r_wstrb;
    assign wb_valid_o       = r_wb_valid;
    assign wb_rd_o          = r_wb_rd;
    assign wb_data_o        = r_wb_data;
    assign exc_misaligned_o = r_exc_mis;
    assign exc_buserr_o     = r_exc_bus;
    assign exc_addr_o       = r_exc_addr;

endmodule
`default_nettype wire
